// File: rtl/g9_pkg.sv
// g9_pkg: shared definitions for the G9 boot loader.
//   loader_state_e    - loader FSM states
//   MEM_WORDS         - instruction memory depth in words
//   LOADER_HDR_BYTES  - length header size in bytes (big-endian word count)
//   WORD_BYTES        - bytes per instruction word
package g9_pkg;

    localparam int MEM_WORDS        = 512;
    localparam int LOADER_HDR_BYTES = 2;
    localparam int WORD_BYTES       = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_e;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: assembles a big-endian instruction word from a byte stream.
//   clk           in   system clock
//   reset         in   asynchronous active-high reset
//   clear_i       in   restart assembly at byte 0 of a word
//   byte_valid_i  in   byte_i is consumed this cycle
//   byte_i        in   stream byte, MSB of the word first
//   word_o        out  assembled word, valid while word_valid_o is high
//   word_valid_o  out  strobe: the byte consumed this cycle completes a word
module imem_word_packer
    import g9_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_i,
    output logic [size-1:0] word_o,
    output logic            word_valid_o
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Only the first three bytes need storing; the fourth is taken straight
    // from the input so the completed word is available in the same cycle.
    logic [size-9:0]  shift_q, shift_d;
    logic             last_byte;

    assign last_byte    = (cnt_q == CNT_W'(WORD_BYTES - 1));
    assign word_valid_o = byte_valid_i && last_byte;
    assign word_o       = {shift_q, byte_i};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            cnt_d   = cnt_q + CNT_W'(1);  // wraps to 0 after the last byte
            shift_d = {shift_q[size-17:0], byte_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the G9 core. Receives a framed
// byte stream (LEN_HI, LEN_LO, N x 4 data bytes MSB first, XOR checksum),
// writes each word to instruction memory and releases the core on success.
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   load_start  in   single-cycle load request (honoured in IDLE/DONE/ERROR)
//   rx_valid    in   rx_data holds a valid byte
//   rx_data     in   stream byte
//   rx_ready    out  loader accepts a byte this cycle
//   wea         out  instruction memory write enable (one-cycle pulse)
//   addra       out  word address, zero-extended from AddrWidth
//   dina        out  write data
//   cpu_reset   out  holds the core in reset until a successful load
//   done        out  load finished with matching checksum
//   error       out  load aborted (overlength or bad checksum)
module imem_loader
    import g9_pkg::*;
#(
    parameter int size      = 32,
    parameter int MemSize   = MEM_WORDS,
    parameter int AddrWidth = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_start,
    input  logic            rx_valid,
    input  logic [7:0]      rx_data,
    output logic            rx_ready,
    output logic            wea,
    output logic [size-1:0] addra,
    output logic [size-1:0] dina,
    output logic            cpu_reset,
    output logic            done,
    output logic            error
);

    localparam int LEN_W = 8 * LOADER_HDR_BYTES;
    localparam int IDX_W = AddrWidth + 1;  // holds MemSize itself

    loader_state_e state_q, state_d;

    logic [7:0]           len_hi_q, len_hi_d;
    logic [IDX_W-1:0]     n_q, n_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [7:0]           xor_q, xor_d;
    logic                 wea_q, wea_d;
    logic [AddrWidth-1:0] addra_q, addra_d;
    logic [size-1:0]      dina_q, dina_d;
    logic                 done_q, error_q, cpu_reset_q;

    logic                 xfer;
    logic                 start;
    logic [LEN_W-1:0]     len_full;
    logic [size-1:0]      word;
    logic                 word_valid;

    assign rx_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CSUM);
    assign xfer     = rx_valid && rx_ready;
    assign start    = load_start &&
                      ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign len_full = {len_hi_q, rx_data};

    imem_word_packer #(
        .size(size)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (start),
        .byte_valid_i(xfer && (state_q == ST_DATA)),
        .byte_i      (rx_data),
        .word_o      (word),
        .word_valid_o(word_valid)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        wea_d    = 1'b0;
        addra_d  = addra_q;
        dina_d   = dina_q;

        // Every byte ahead of the checksum itself feeds the running XOR.
        if (xfer && (state_q != ST_CSUM)) begin
            xor_d = xor_q ^ rx_data;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_LEN_HI;
                    idx_d   = '0;
                    xor_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_full > LEN_W'(MemSize)) begin
                        state_d = ST_ERROR;
                    end else begin
                        // Safe truncation: length already bounded by MemSize.
                        n_d     = IDX_W'(len_full);
                        state_d = (len_full == '0) ? ST_CSUM : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid) begin
                    wea_d   = 1'b1;
                    addra_d = idx_q[AddrWidth-1:0];
                    dina_d  = word;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_d == n_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == xor_q) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_hi_q    <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            xor_q       <= '0;
            wea_q       <= 1'b0;
            addra_q     <= '0;
            dina_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_hi_q    <= len_hi_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            wea_q       <= wea_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            // Status flags are registered from the next state so they rise
            // in the same cycle the FSM enters DONE/ERROR.
            done_q      <= (state_d == ST_DONE);
            error_q     <= (state_d == ST_ERROR);
            cpu_reset_q <= (state_d != ST_DONE);
        end
    end

    assign wea       = wea_q;
    assign addra     = {{(size - AddrWidth){1'b0}}, addra_q};
    assign dina      = dina_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Frames are built as
// byte queues; a frame-level model derives the expected memory writes and the
// final done/error outcome, and a negedge monitor checks every wea pulse.
module tb_imem_loader;
    import g9_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wea;
    logic [31:0] addra;
    logic [31:0] dina;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  frame[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          exp_done;
    int          wr_seen;

    imem_loader #(
        .size     (32),
        .MemSize  (512),
        .AddrWidth(9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: decode length, collect words, compare checksum.
    function automatic void build_model();
        int          n;
        logic [7:0]  acc;
        exp_addr.delete();
        exp_data.delete();
        n = {frame[0], frame[1]};
        if (n > MEM_WORDS) begin
            exp_done = 1'b0;
            return;
        end
        acc = 8'h00;
        for (int i = 0; i < 2 + 4 * n; i++) acc ^= frame[i];
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(32'(w));
            exp_data.push_back({frame[2+4*w], frame[3+4*w], frame[4+4*w], frame[5+4*w]});
        end
        exp_done = (frame[2 + 4 * n] == acc);
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && wea === 1'b1) begin
            if (wr_seen < exp_addr.size()) begin
                check($sformatf("wr%0d_addra", wr_seen), addra, exp_addr[wr_seen]);
                check($sformatf("wr%0d_dina", wr_seen), dina, exp_data[wr_seen]);
            end else begin
                check("extra_wea_count", 32'(wr_seen + 1), 32'(exp_addr.size()));
            end
            wr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic load_case1(input logic [7:0] csum);
        frame = {8'h00, 8'h02, 8'h20, 8'h22, 8'h00, 8'h05,
                 8'h8C, 8'h01, 8'hFF, 8'hFF, csum};
    endtask

    task automatic make_random(input int n, input bit bad);
        logic [7:0] acc;
        logic [7:0] b;
        frame.delete();
        frame.push_back(8'(n >> 8));
        frame.push_back(8'(n));
        acc = 8'(n >> 8) ^ 8'(n);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frame.push_back(b);
            acc ^= b;
        end
        frame.push_back(bad ? (acc ^ 8'($urandom_range(1, 255))) : acc);
    endtask

    // gap_mode: 0 = back-to-back, 1 = every other cycle, 2 = random gaps.
    // ls_at: byte index after which a stray load_start is pulsed (-1 = none).
    task automatic send_frame(input int gap_mode, input int ls_at, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            rx_valid = 1'b1;
            rx_data  = frame[i];
            if (i == 0 || i == nbytes - 1) check($sformatf("rx_ready_b%0d", i), rx_ready, 1'b1);
            if (i == nbytes - 1) begin
                check("busy_done", done, 1'b0);
                check("busy_cpu_reset", cpu_reset, 1'b1);
            end
            tick();
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                load_start = (i == ls_at);
                tick();
                load_start = 1'b0;
            end
        end
    endtask

    task automatic run_case(input string name, input int gap_mode, input int ls_at);
        build_model();
        wr_seen = 0;
        start_load();
        send_frame(gap_mode, ls_at, frame.size());
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, !exp_done);
        check({name, "_cpu_reset"}, cpu_reset, !exp_done);
        check({name, "_rx_ready"}, rx_ready, 1'b0);
        tick();
        tick();
        check({name, "_wr_count"}, 32'(wr_seen), 32'(exp_addr.size()));
        check({name, "_done_hold"}, done, exp_done);
    endtask

    initial begin
        reset      = 1'b1;
        load_start = 1'b0;
        rx_valid   = 1'b0;
        rx_data    = 8'h00;
        wr_seen    = 0;
        tick();
        tick();
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_wea", wea, 1'b0);
        check("rst_addra", addra, 32'h0);
        check("rst_dina", dina, 32'h0);
        check("rst_cpu_reset", cpu_reset, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        reset = 1'b0;
        tick();

        // Reference two-word program.
        load_case1(8'h88);
        run_case("case1", 0, -1);
        check("case1_w1_data", exp_data[1], 32'h8C01FFFF);

        // Bytes offered while DONE are not consumed.
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        check("done_rx_ready", rx_ready, 1'b0);
        tick();
        rx_valid = 1'b0;
        check("done_after_stray", done, 1'b1);

        // Bad checksum: writes still happen, error raised.
        load_case1(8'h89);
        run_case("badcsum", 0, -1);

        // Overlength N=513 rejected right after LEN_LO.
        frame = {8'h02, 8'h01};
        run_case("overlen", 0, -1);

        // Empty program.
        frame = {8'h00, 8'h00, 8'h00};
        run_case("empty", 0, -1);

        // Full-depth load, last write at addra=511.
        make_random(MEM_WORDS, 1'b0);
        run_case("full512", 0, -1);
        check("full512_last_addr", exp_addr[MEM_WORDS-1], 32'd511);

        // Every-other-cycle valid with a stray load_start during DATA.
        load_case1(8'h88);
        run_case("gapped", 1, 5);

        // Reset part-way through a load.
        load_case1(8'h88);
        build_model();
        wr_seen = 0;
        start_load();
        send_frame(0, -1, 8);
        reset = 1'b1;
        #1;
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_wea", wea, 1'b0);
        check("midrst_addra", addra, 32'h0);
        check("midrst_dina", dina, 32'h0);
        check("midrst_cpu_reset", cpu_reset, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_error", error, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check("midrst_wr_count", 32'(wr_seen), 32'd1);
        tick();
        check("midrst_still_reset", cpu_reset, 1'b1);
        run_case("after_rst", 0, -1);

        // Random short programs with random checksum errors and gaps.
        for (int k = 0; k < 6; k++) begin
            make_random($urandom_range(1, 8), ($urandom_range(0, 2) == 0));
            run_case($sformatf("rand%0d", k), 2, 3);
        end

        // Boundary N=512 accepted vs 513 already covered; N=1 good frame.
        make_random(1, 1'b0);
        run_case("single", 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
